// File: rtl/proc_run_ctrl.sv
// Processor run controller: reset sequencing, run-cycle budget, tohost completion mailbox.
// Optional console output port enabled by defining RUN_CTRL_CONSOLE_EN.
module proc_run_ctrl #(
  parameter int unsigned      dataW        = 32,
  parameter int unsigned      addrW        = 16,
  parameter int unsigned      RESET_CYCLES = 2,
  parameter int unsigned      MAX_CYCLES   = 64,
  parameter logic [addrW-1:0] TOHOST_ADDR  = addrW'(16'hFFF0),
  parameter logic [addrW-1:0] CONSOLE_ADDR = addrW'(16'hFFF4)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [addrW-1:0] wr_addr,
  input  logic [dataW-1:0] wr_data,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [dataW-2:0] exit_code,
  output logic [31:0]      cycle_count,
  output logic             console_valid,
  output logic [7:0]       console_data
);

  localparam int unsigned RST_W = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);
  localparam int unsigned EXT_W = dataW - 1;
`ifdef RUN_CTRL_CONSOLE_EN
  localparam bit CON_EN = 1'b1;
`else
  localparam bit CON_EN = 1'b0;
`endif

  typedef enum logic [1:0] {RST_SEQ, RUN, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [RST_W-1:0]   r_rst_cnt, w_rst_cnt_nxt;
  logic               r_core_reset, w_core_reset_nxt;
  logic               r_running, w_running_nxt;
  logic               r_done, w_done_nxt;
  logic               r_pass, w_pass_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic [EXT_W-1:0]   r_exit_code, w_exit_code_nxt;
  logic [31:0]        r_cycle_count, w_cycle_count_nxt;
  logic               r_con_valid, w_con_valid_nxt;
  logic [7:0]         r_con_data, w_con_data_nxt;
  logic               w_tohost_hit;
  logic               w_console_hit;

  assign w_tohost_hit  = wr_en && (wr_addr == TOHOST_ADDR) && wr_data[0];
  assign w_console_hit = CON_EN && wr_en && (wr_addr == CONSOLE_ADDR);

  // Next-state and next-output logic; every register holds unless a transition updates it.
  always_comb begin
    w_state_nxt       = r_state;
    w_rst_cnt_nxt     = r_rst_cnt;
    w_core_reset_nxt  = r_core_reset;
    w_running_nxt     = r_running;
    w_done_nxt        = r_done;
    w_pass_nxt        = r_pass;
    w_timeout_nxt     = r_timeout;
    w_exit_code_nxt   = r_exit_code;
    w_cycle_count_nxt = r_cycle_count;
    w_con_valid_nxt   = 1'b0;
    w_con_data_nxt    = r_con_data;
    case (r_state)
      RST_SEQ: begin
        if (r_rst_cnt == RST_W'(RESET_CYCLES)) begin
          w_state_nxt      = RUN;
          w_rst_cnt_nxt    = '0;
          w_core_reset_nxt = 1'b0;
          w_running_nxt    = 1'b1;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + RST_W'(1);
        end
      end
      RUN: begin
        if (r_cycle_count != 32'hFFFF_FFFF) w_cycle_count_nxt = r_cycle_count + 32'd1;
        if (w_console_hit) begin
          w_con_valid_nxt = 1'b1;
          w_con_data_nxt  = wr_data[7:0];
        end
        // A completing tohost write takes priority over an expiring budget.
        if (w_tohost_hit) begin
          w_state_nxt      = DONE;
          w_core_reset_nxt = 1'b1;
          w_running_nxt    = 1'b0;
          w_done_nxt       = 1'b1;
          w_exit_code_nxt  = wr_data[dataW-1:1];
          w_pass_nxt       = (wr_data[dataW-1:1] == '0);
          w_timeout_nxt    = 1'b0;
        end else if (r_cycle_count == 32'(MAX_CYCLES - 1)) begin
          w_state_nxt      = DONE;
          w_core_reset_nxt = 1'b1;
          w_running_nxt    = 1'b0;
          w_done_nxt       = 1'b1;
          w_exit_code_nxt  = '0;
          w_pass_nxt       = 1'b0;
          w_timeout_nxt    = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = DONE;
      end
      default: begin
        w_state_nxt = RST_SEQ;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= RST_SEQ;
      r_rst_cnt     <= '0;
      r_core_reset  <= 1'b1;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_timeout     <= 1'b0;
      r_exit_code   <= '0;
      r_cycle_count <= '0;
      r_con_valid   <= 1'b0;
      r_con_data    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_rst_cnt     <= w_rst_cnt_nxt;
      r_core_reset  <= w_core_reset_nxt;
      r_running     <= w_running_nxt;
      r_done        <= w_done_nxt;
      r_pass        <= w_pass_nxt;
      r_timeout     <= w_timeout_nxt;
      r_exit_code   <= w_exit_code_nxt;
      r_cycle_count <= w_cycle_count_nxt;
      r_con_valid   <= w_con_valid_nxt;
      r_con_data    <= w_con_data_nxt;
    end
  end

  assign core_reset    = r_core_reset;
  assign running       = r_running;
  assign done          = r_done;
  assign pass          = r_pass;
  assign timeout       = r_timeout;
  assign exit_code     = r_exit_code;
  assign cycle_count   = r_cycle_count;
  assign console_valid = r_con_valid;
  assign console_data  = r_con_data;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl in its default build (console disabled).
`timescale 1ns/1ps
module tb_proc_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_reset, running, done, pass, timeout, console_valid;
  logic [30:0] exit_code;
  logic [31:0] cycle_count;
  logic [7:0]  console_data;

  int n_total = 0;
  int n_pass  = 0;

  proc_run_ctrl dut (
    .clock(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_reset(core_reset), .running(running), .done(done), .pass(pass),
    .timeout(timeout), .exit_code(exit_code), .cycle_count(cycle_count),
    .console_valid(console_valid), .console_data(console_data)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic snap(input string tag, input logic cr, input logic rn, input logic dn,
                      input logic ps, input logic to, input logic [30:0] ec,
                      input logic [31:0] cc);
    chk({tag, ".core_reset"},    32'(core_reset),    32'(cr));
    chk({tag, ".running"},       32'(running),       32'(rn));
    chk({tag, ".done"},          32'(done),          32'(dn));
    chk({tag, ".pass"},          32'(pass),          32'(ps));
    chk({tag, ".timeout"},       32'(timeout),       32'(to));
    chk({tag, ".exit_code"},     32'(exit_code),     32'(ec));
    chk({tag, ".cycle_count"},   cycle_count,        cc);
    chk({tag, ".console_valid"}, 32'(console_valid), 32'd0);
    chk({tag, ".console_data"},  32'(console_data),  32'd0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic restart();
    reset = 1'b0; wr_en = 1'b0;
    step(1);
    reset = 1'b1;
    step(3);
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step(2);
    snap("reset", 1, 0, 0, 0, 0, 0, 0);

    // Release: core_reset held for two cycles after the first reset-high cycle.
    reset = 1'b1;
    step(1); snap("rseq1", 1, 0, 0, 0, 0, 0, 0);
    step(1); snap("rseq2", 1, 0, 0, 0, 0, 0, 0);
    step(1); snap("run0",  0, 1, 0, 0, 0, 0, 0);
    step(2); snap("run2",  0, 1, 0, 0, 0, 0, 2);

    wr(16'hFFF0, 32'h6); step(1); snap("tohost_even", 0, 1, 0, 0, 0, 0, 3);
    wr(16'h1234, 32'h1); step(1); snap("other_addr",  0, 1, 0, 0, 0, 0, 4);
    wr(16'hFFF4, 32'h48); step(1); snap("console_off", 0, 1, 0, 0, 0, 0, 5);
    wr(16'hFFF0, 32'h7); step(1); wr_en = 1'b0;
    snap("tohost7", 1, 0, 1, 0, 0, 3, 6);
    wr(16'hFFF0, 32'h1); step(2); wr_en = 1'b0;
    snap("done_hold", 1, 0, 1, 0, 0, 3, 6);

    restart();
    snap("r2_run0", 0, 1, 0, 0, 0, 0, 0);
    step(1);
    wr(16'hFFF0, 32'h1); step(1); wr_en = 1'b0;
    snap("tohost1", 1, 0, 1, 1, 0, 0, 2);

    restart();
    step(63); snap("pre_tmo", 0, 1, 0, 0, 0, 0, 63);
    step(1);  snap("timeout", 1, 0, 1, 0, 1, 0, 64);
    step(2);  snap("tmo_hold", 1, 0, 1, 0, 1, 0, 64);

    restart();
    step(63);
    wr(16'hFFF0, 32'h1); step(1); wr_en = 1'b0;
    snap("tohost_vs_tmo", 1, 0, 1, 1, 0, 0, 64);

    restart();
    wr(16'hFFF0, 32'hFFFF_FFFF); step(1); wr_en = 1'b0;
    snap("exit_max", 1, 0, 1, 0, 0, 31'h7FFF_FFFF, 1);

    restart();
    step(20); snap("mid_run", 0, 1, 0, 0, 0, 0, 20);
    reset = 1'b0; step(1);
    snap("mid_reset", 1, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(2); snap("mid_rseq", 1, 0, 0, 0, 0, 0, 0);
    step(1); snap("mid_run0", 0, 1, 0, 0, 0, 0, 0);
    step(1); snap("mid_run1", 0, 1, 0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/proc_run_ctrl.md
PROC_RUN_CTRL -- requirements
Module: proc_run_ctrl

Interface
REQ-001 SHALL have parameter dataW, default 32, store-bus data width (>= 16).
REQ-002 SHALL have parameter addrW, default 16, store-bus byte-address width.
REQ-003 SHALL have parameter RESET_CYCLES, default 2, number of cycles core_reset is held after reset release (>= 1).
REQ-004 SHALL have parameter MAX_CYCLES, default 64, run-phase cycle budget before timeout (>= 2).
REQ-005 SHALL have parameter TOHOST_ADDR, default 16'hFFF0, completion-mailbox address.
REQ-006 SHALL have parameter CONSOLE_ADDR, default 16'hFFF4, character-output address.
REQ-007 SHALL have ports: clock  in  1  system clock, rising edge.
REQ-008 SHALL have: reset  in  1  synchronous, active-low reset.
REQ-009 SHALL have: wr_en  in  1  core store strobe, one write per asserted cycle.
REQ-010 SHALL have: wr_addr  in  addrW  store byte address.
REQ-011 SHALL have: wr_data  in  dataW  store data.
REQ-012 SHALL have: core_reset  out  1  active-high reset to the processor.
REQ-013 SHALL have: running  out  1  high in RUN state.
REQ-014 SHALL have: done  out  1  sticky, run finished.
REQ-015 SHALL have: pass  out  1  sticky, finished with exit code 0.
REQ-016 SHALL have: timeout  out  1  sticky, finished by cycle budget.
REQ-017 SHALL have: exit_code  out  dataW-1  wr_data[dataW-1:1] of the completing tohost write.
REQ-018 SHALL have: cycle_count  out  32  RUN cycles elapsed.
REQ-019 SHALL have: console_valid  out  1  one-cycle strobe per console byte; console_data  out  8  byte.

Function
REQ-020 SHALL implement FSM states RST_SEQ, RUN, DONE, all outputs registered.
REQ-021 RST_SEQ SHALL hold core_reset=1 for exactly RESET_CYCLES cycles after the first cycle with reset=1, then enter RUN.
REQ-022 RUN SHALL drive core_reset=0, running=1, and increment cycle_count by 1 each cycle, saturating at 32'hFFFF_FFFF.
REQ-023 In RUN, wr_en=1 with wr_addr==TOHOST_ADDR and wr_data[0]=1 SHALL, next cycle: done=1, exit_code=wr_data[dataW-1:1], pass=(exit_code==0), enter DONE.
REQ-024 A tohost write with wr_data[0]=0 SHALL be ignored.
REQ-025 In RUN, when cycle_count==MAX_CYCLES-1 and no completing tohost write occurs that cycle, next cycle SHALL set done=1, timeout=1, pass=0, exit_code=0, and enter DONE.
REQ-026 Completing tohost write and timeout in the same cycle: tohost SHALL win, timeout=0.
REQ-027 DONE SHALL reassert core_reset=1, clear running, freeze cycle_count, and keep done/pass/timeout/exit_code until reset.
REQ-028 Writes SHALL be ignored in RST_SEQ and DONE; writes to addresses other than TOHOST_ADDR/CONSOLE_ADDR SHALL be ignored.

Reset
REQ-029 reset=0 SHALL, at the next clock edge, force RST_SEQ with core_reset=1, running=0, done=0, pass=0, timeout=0, exit_code=0, cycle_count=0, console_valid=0, console_data=0, from any state including mid-RUN.
REQ-030 The RESET_CYCLES count SHALL restart from zero on every reset release.

Configuration
REQ-031 With RUN_CTRL_CONSOLE_EN defined, a RUN-state write to CONSOLE_ADDR SHALL produce console_valid=1 and console_data=wr_data[7:0] for exactly the next cycle.
REQ-032 Without RUN_CTRL_CONSOLE_EN, console_valid and console_data SHALL be constant 0 and CONSOLE_ADDR writes ignored.

Verification
REQ-033 Reset low 2 cycles then high, RESET_CYCLES=2 -> core_reset=1 for 2 cycles after release, then running=1, cycle_count counts 0,1,2,...
REQ-034 In RUN, write TOHOST_ADDR data 32'h1 -> next cycle done=1, pass=1, exit_code=0, core_reset=1, cycle_count frozen.
REQ-035 In RUN, write TOHOST_ADDR data 32'h7 -> done=1, pass=0, exit_code=3; earlier write of 32'h6 ignored.
REQ-036 No tohost write, MAX_CYCLES=64 -> done=1, timeout=1, pass=0 one cycle after cycle_count==63; tohost data 1 on that same cycle -> pass=1, timeout=0.
REQ-037 With RUN_CTRL_CONSOLE_EN, writes 8'h48 then 8'h69 to CONSOLE_ADDR on consecutive cycles -> two consecutive console_valid pulses carrying 8'h48, 8'h69; without macro -> console_valid stays 0.
REQ-038 Reset low mid-RUN at cycle_count=20 -> all outputs to reset values next edge, RST_SEQ restarts, count resumes from 0.
